// File: rtl/pfft_mant_norm_round.sv
`default_nettype none
// ============================================================================
// pfft_mant_norm_round : normalise, RNE-round and saturate a mantissa product
// Rev 1.0 - initial release
// ============================================================================
module pfft_mant_norm_round #(
    parameter int PROD_W = 79,
    parameter int FRAC_W = 32,
    parameter int EXP_W  = 10
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam int LZC_W = $clog2(PROD_W + 1);
    localparam int EW    = EXP_W + 8;
    localparam logic [EW-1:0] EMAX = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMIN = ~EMAX;

    logic en;

    // Stage 1 registers
    logic              v1_q;
    logic [PROD_W-1:0] prod1_q;
    logic [EXP_W-1:0]  exp1_q;
    logic [LZC_W-1:0]  lzc1_q;
    logic [LZC_W-1:0]  lzc1_d;

    // Stage 2 registers
    logic              v2_q;
    logic [FRAC_W-1:0] keep2_q;
    logic              guard2_q;
    logic              sticky2_q;
    logic              zero2_q;
    logic [EW-1:0]     e2_q;
    logic [PROD_W-1:0] norm2;
    logic [FRAC_W-1:0] keep2_d;
    logic              guard2_d;
    logic              sticky2_d;
    logic              zero2_d;
    logic [EW-1:0]     e2_d;

    // Stage 3 (output) registers
    logic              v3_q;
    logic [FRAC_W-1:0] mant3_q;
    logic [EXP_W-1:0]  exp3_q;
    logic              zero3_q;
    logic              ovf3_q;
    logic              unf3_q;
    logic              rnd3;
    logic [FRAC_W:0]   sum3;
    logic [EW-1:0]     e3;
    logic [FRAC_W-1:0] mant3_d;
    logic [EXP_W-1:0]  exp3_d;
    logic              ovf3_d;
    logic              unf3_d;

    assign en       = out_ready | ~v3_q;
    assign in_ready = en;

    // Highest set bit wins, so the last match in ascending order is kept.
    always_comb begin
        lzc1_d = LZC_W'(PROD_W);
        for (int i = 0; i < PROD_W; i++) begin
            if (in_prod[i]) lzc1_d = LZC_W'(PROD_W - 1 - i);
        end
    end

    always_comb begin
        norm2     = prod1_q << lzc1_q;
        keep2_d   = norm2[PROD_W-1 -: FRAC_W];
        guard2_d  = norm2[PROD_W-1-FRAC_W];
        sticky2_d = |norm2[PROD_W-2-FRAC_W:0];
        zero2_d   = (lzc1_q == LZC_W'(PROD_W));
        e2_d      = {{(EW-EXP_W){exp1_q[EXP_W-1]}}, exp1_q} + EW'(1) - EW'(lzc1_q);
    end

    // A carry out of the rounding add means keep was all ones: result is 1.000...
    always_comb begin
        rnd3    = guard2_q & (sticky2_q | keep2_q[0]);
        sum3    = {1'b0, keep2_q} + (FRAC_W+1)'(rnd3);
        mant3_d = sum3[FRAC_W] ? {1'b1, {(FRAC_W-1){1'b0}}} : sum3[FRAC_W-1:0];
        e3      = e2_q + EW'(sum3[FRAC_W]);
        exp3_d  = e3[EXP_W-1:0];
        ovf3_d  = 1'b0;
        unf3_d  = 1'b0;
        if ($signed(e3) > $signed(EMAX)) begin
            exp3_d = EMAX[EXP_W-1:0];
            ovf3_d = 1'b1;
        end else if ($signed(e3) < $signed(EMIN)) begin
            exp3_d = EMIN[EXP_W-1:0];
            unf3_d = 1'b1;
        end
        if (zero2_q) begin
            mant3_d = '0;
            exp3_d  = '0;
            ovf3_d  = 1'b0;
            unf3_d  = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            v1_q      <= 1'b0;
            prod1_q   <= '0;
            exp1_q    <= '0;
            lzc1_q    <= '0;
            v2_q      <= 1'b0;
            keep2_q   <= '0;
            guard2_q  <= 1'b0;
            sticky2_q <= 1'b0;
            zero2_q   <= 1'b0;
            e2_q      <= '0;
            v3_q      <= 1'b0;
            mant3_q   <= '0;
            exp3_q    <= '0;
            zero3_q   <= 1'b0;
            ovf3_q    <= 1'b0;
            unf3_q    <= 1'b0;
        end else if (en) begin
            v1_q      <= in_valid;
            prod1_q   <= in_prod;
            exp1_q    <= in_exp;
            lzc1_q    <= lzc1_d;
            v2_q      <= v1_q;
            keep2_q   <= keep2_d;
            guard2_q  <= guard2_d;
            sticky2_q <= sticky2_d;
            zero2_q   <= zero2_d;
            e2_q      <= e2_d;
            v3_q      <= v2_q;
            mant3_q   <= mant3_d;
            exp3_q    <= exp3_d;
            zero3_q   <= zero2_q;
            ovf3_q    <= ovf3_d;
            unf3_q    <= unf3_d;
        end
    end

    assign out_valid = v3_q;
    assign out_mant  = mant3_q;
    assign out_exp   = exp3_q;
    assign out_zero  = zero3_q;
    assign out_ovf   = ovf3_q;
    assign out_unf   = unf3_q;

endmodule
`default_nettype wire

// File: tb/tb_pfft_mant_norm_round.sv
`default_nettype none
// ============================================================================
// tb_pfft_mant_norm_round : directed self-checking bench for the normaliser
// Rev 1.0 - initial release
// ============================================================================
module tb_pfft_mant_norm_round;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [78:0] in_prod;
    logic [9:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mant;
    logic [9:0]  out_exp;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int checks = 0;
    int errors = 0;

    pfft_mant_norm_round #(
        .PROD_W (79),
        .FRAC_W (32),
        .EXP_W  (10)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Single beat with out_ready high: result must appear exactly after the third edge.
    task automatic run_one(input string tag, input logic [78:0] p, input logic [9:0] e,
                           input logic [31:0] em, input logic [9:0] ee,
                           input logic ez, input logic eo, input logic eu);
        @(negedge ap_clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_prod   = p;
        in_exp    = e;
        #1 chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge ap_clk);
        #1 in_valid = 1'b0;
        chk({tag, "_v1"}, 64'(out_valid), 64'd0);
        @(posedge ap_clk);
        #1 chk({tag, "_v2"}, 64'(out_valid), 64'd0);
        @(posedge ap_clk);
        #1 chk({tag, "_v3"}, 64'(out_valid), 64'd1);
        chk({tag, "_mant"}, 64'(out_mant), 64'(em));
        chk({tag, "_exp"}, 64'(out_exp), 64'(ee));
        chk({tag, "_flags"}, 64'({out_zero, out_ovf, out_unf}), 64'({ez, eo, eu}));
        @(posedge ap_clk);
        #1 chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    function automatic logic [78:0] beat_prod(input int k);
        logic [78:0] p;
        p = (79'd1 << 77) | (79'(k) << 46);
        return p;
    endfunction

    initial begin
        int          sent;
        int          recv;
        logic        hold;
        logic [31:0] snap_m;
        logic [9:0]  snap_e;

        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_exp    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_outs", 64'({out_mant, out_exp, out_zero, out_ovf, out_unf}), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        run_one("unit",   79'd1 << 77, 10'd0, 32'h8000_0000, 10'd0, 1'b0, 1'b0, 1'b0);
        run_one("msb78",  79'd1 << 78, 10'd5, 32'h8000_0000, 10'd6, 1'b0, 1'b0, 1'b0);
        run_one("tie_ev", (79'd1 << 77) | (79'd1 << 45), 10'd0,
                32'h8000_0000, 10'd0, 1'b0, 1'b0, 1'b0);
        run_one("tie_od", (79'd1 << 77) | (79'd1 << 46) | (79'd1 << 45), 10'd0,
                32'h8000_0002, 10'd0, 1'b0, 1'b0, 1'b0);
        run_one("carry",  (79'd1 << 78) - 79'd1, 10'd0, 32'h8000_0000, 10'd1, 1'b0, 1'b0, 1'b0);
        run_one("ovf",    79'd1 << 78, 10'd511, 32'h8000_0000, 10'd511, 1'b0, 1'b1, 1'b0);
        run_one("edge_ok", 79'd1 << 77, 10'd511, 32'h8000_0000, 10'd511, 1'b0, 1'b0, 1'b0);
        run_one("unf",    79'd1, -10'sd500, 32'h8000_0000, 10'h200, 1'b0, 1'b0, 1'b1);
        run_one("zero",   79'd0, 10'd77, 32'h0, 10'd0, 1'b1, 1'b0, 1'b0);

        // Stream 10 beats; consumer stalls during loop cycles 4..7.
        sent = 0;
        recv = 0;
        hold = 1'b0;
        snap_m = '0;
        snap_e = '0;
        for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
            @(negedge ap_clk);
            if (hold) begin
                chk("frz_valid", 64'(out_valid), 64'd1);
                chk("frz_data", 64'({out_mant, out_exp}), 64'({snap_m, snap_e}));
            end
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = (sent < 10);
            in_prod   = beat_prod(sent + 1);
            in_exp    = 10'(sent + 1);
            #1;
            if (out_valid && out_ready) begin
                chk("str_mant", 64'(out_mant), 64'(32'h8000_0000 + 32'(recv + 1)));
                chk("str_exp", 64'(out_exp), 64'(10'(recv + 1)));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            hold   = out_valid && !out_ready;
            snap_m = out_mant;
            snap_e = out_exp;
        end
        chk("str_count", 64'(recv), 64'd10);
        @(negedge ap_clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge ap_clk);
            #1 chk("str_nodup", 64'(out_valid), 64'd0);
        end

        // Reset while the pipeline is full.
        for (int k = 1; k <= 4; k++) begin
            @(negedge ap_clk);
            in_valid = 1'b1;
            in_prod  = beat_prod(k);
            in_exp   = 10'(k);
        end
        @(negedge ap_clk);
        chk("mid_full", 64'(out_valid), 64'd1);
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge ap_clk);
        #1 chk("mid_rst_v", 64'(out_valid), 64'd0);
        chk("mid_rst_m", 64'(out_mant), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1 chk("mid_rdy", 64'(in_ready), 64'd1);
        repeat (5) begin
            @(posedge ap_clk);
            #1 chk("mid_stale", 64'(out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
